clock_gen_multi: RTL

Multi-channel programmable clock generator replacing the fixed single-output divider. Each of CHANNELS channels divides clock_in by a runtime-writable half-period and produces a 50%-duty divided clock plus a one-cycle tick strobe on every toggle. Divisor updates are glitch-free, taking effect only at a channel's terminal count. The block sits beside the CPU/peripheral logic and supplies slow display, blink and baud-style timebases from the 50 MHz board clock.

---
 rtl/clock_gen_multi.sv | 91 +++++++++
 1 files changed

// File: rtl/clock_gen_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor updates at terminal count.
// Optional CLKGEN_SYNC_EN adds a sync_start input that phase-aligns all channels.
module clock_gen_multi #(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 26,
    parameter int SEL_WIDTH   = 2,
    parameter int DEFAULT_DIV = 25000000
) (
    input  logic                 clock_in,
    input  logic                 reset,
`ifdef CLKGEN_SYNC_EN
    input  logic                 sync_start,
`endif
    input  logic [CHANNELS-1:0]  ch_enable,
    input  logic                 wr_en,
    input  logic [SEL_WIDTH-1:0] wr_chan,
    input  logic [CNT_WIDTH-1:0] wr_div,
    output logic                 wr_err,
    output logic [CHANNELS-1:0]  clock_out,
    output logic [CHANNELS-1:0]  tick
);

    localparam logic [CNT_WIDTH-1:0] DIV_RESET  = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [SEL_WIDTH:0]   CHAN_LIMIT = (SEL_WIDTH + 1)'(CHANNELS);

    logic sync_hit;
    logic wr_err_reg;

`ifdef CLKGEN_SYNC_EN
    assign sync_hit = sync_start;
`else
    assign sync_hit = 1'b0;
`endif

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            wr_err_reg <= 1'b0;
        end else begin
            wr_err_reg <= wr_en && ({1'b0, wr_chan} >= CHAN_LIMIT);
        end
    end

    assign wr_err = wr_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [CNT_WIDTH-1:0] count_reg;
            logic [CNT_WIDTH-1:0] div_active_reg;
            logic [CNT_WIDTH-1:0] div_pending_reg;
            logic                 clock_reg;
            logic                 tick_reg;

            // Writes only touch the pending divisor; the active one swaps at terminal/idle.
            always_ff @(posedge clock_in or posedge reset) begin
                if (reset) begin
                    div_pending_reg <= DIV_RESET;
                end else if (wr_en && (wr_chan == SEL_WIDTH'(gi))) begin
                    div_pending_reg <= wr_div;
                end
            end

            // >= keeps a divisor lowered below the running count from wrapping the counter.
            always_ff @(posedge clock_in or posedge reset) begin
                if (reset) begin
                    count_reg      <= '0;
                    div_active_reg <= DIV_RESET;
                    clock_reg      <= 1'b0;
                    tick_reg       <= 1'b0;
                end else if (sync_hit || !ch_enable[gi]) begin
                    count_reg      <= '0;
                    div_active_reg <= div_pending_reg;
                    clock_reg      <= 1'b0;
                    tick_reg       <= 1'b0;
                end else if (count_reg >= div_active_reg) begin
                    count_reg      <= '0;
                    div_active_reg <= div_pending_reg;
                    clock_reg      <= ~clock_reg;
                    tick_reg       <= 1'b1;
                end else begin
                    count_reg      <= count_reg + 1'b1;
                    tick_reg       <= 1'b0;
                end
            end

            assign clock_out[gi] = clock_reg;
            assign tick[gi]      = tick_reg;
        end
    endgenerate

endmodule
